// File: rtl/incr_skid_stage.sv
// incr_skid_stage: 2-entry skid buffer that increments each accepted value and counts output transfers
module incr_skid_stage #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_wrap,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] xfer_count
);
    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
    state_t state, state_nxt;
    logic [WIDTH:0] head, tail, inc;
    logic push, pop;
    assign inc = {&in_data, in_data + WIDTH'(1)};
    // Occupancy register
    always_ff @(posedge clk or posedge reset)
        if (reset) state <= EMPTY;
        else state <= state_nxt;
    // Handshakes, next occupancy and zero-gated head outputs
    always_comb begin
        in_ready  = !reset && state != FULL;
        out_valid = state != EMPTY;
        push      = in_valid && in_ready;
        pop       = out_valid && out_ready;
        out_data  = out_valid ? head[WIDTH-1:0] : '0;
        out_wrap  = out_valid && head[WIDTH];
        state_nxt = (push && !pop) ? (state == EMPTY ? ONE : FULL) :
                    (pop && !push) ? (state == FULL ? ONE : EMPTY) : state;
    end
    // Head holds the oldest entry; tail only fills when a push lands behind a head that stays
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            head <= '0;
            tail <= '0;
        end else begin
            if (push && (state == EMPTY || (state == ONE && pop))) head <= inc;
            else if (pop && state == FULL) head <= tail;
            if (push && state == ONE && !pop) tail <= inc;
        end
    // Saturating count of completed output transfers
    always_ff @(posedge clk or posedge reset)
        if (reset) xfer_count <= '0;
        else if (pop && xfer_count != '1) xfer_count <= xfer_count + CNT_W'(1);
endmodule

// File: tb/tb_incr_skid_stage.sv
// tb_incr_skid_stage: randomized and directed checks of incr_skid_stage against a queue model
module tb_incr_skid_stage;
    logic       clk = 0;
    logic       reset = 1;
    logic [7:0] in_data = 0;
    logic       in_valid = 0;
    logic       out_ready = 0;
    logic       in_ready, out_wrap, out_valid;
    logic [7:0] out_data;
    logic [15:0] xfer_count;
    logic       in_ready4, out_wrap4, out_valid4;
    logic [7:0] out_data4;
    logic [3:0] xfer_count4;
    int checks = 0;
    int errors = 0;
    logic [8:0] q[$];
    int cnt = 0;
    int cnt4 = 0;

    incr_skid_stage #(.WIDTH(8), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_wrap(out_wrap), .out_valid(out_valid), .out_ready(out_ready),
        .xfer_count(xfer_count)
    );
    incr_skid_stage #(.WIDTH(8), .CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready4),
        .out_data(out_data4), .out_wrap(out_wrap4), .out_valid(out_valid4), .out_ready(out_ready),
        .xfer_count(xfer_count4)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs, advance the reference queue across the edge, sample 1 time unit later
    task automatic cycle(input logic iv, input logic [7:0] id, input logic ordy);
        logic inf, outf;
        in_valid = iv;
        in_data = id;
        out_ready = ordy;
        inf = iv && (q.size() < 2);
        outf = ordy && (q.size() > 0);
        @(posedge clk);
        if (outf) begin
            void'(q.pop_front());
            if (cnt < 65535) cnt++;
            if (cnt4 < 15) cnt4++;
        end
        if (inf) q.push_back({id == 8'hFF, 8'(id + 8'd1)});
        #1;
    endtask

    task automatic do_reset();
        reset = 1;
        in_valid = 0;
        out_ready = 0;
        #1;
        q.delete();
        cnt = 0;
        cnt4 = 0;
        @(negedge clk);
        reset = 0;
        #1;
    endtask

    task automatic test_reset();
        #3;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
        checks++; if (out_data !== 8'h00 || out_wrap !== 1'b0) begin errors++; $display("FAIL reset_out_data got %h/%b exp 00/0", out_data, out_wrap); end
        checks++; if (xfer_count !== 16'd0) begin errors++; $display("FAIL reset_xfer_count got %0d exp 0", xfer_count); end
        @(negedge clk);
        reset = 0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_in_ready got %b exp 1", in_ready); end
    endtask

    task automatic test_single();
        do_reset();
        cycle(1, 8'h05, 1);
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h06 || out_wrap !== 1'b0) begin errors++; $display("FAIL single_out got v=%b d=%h w=%b exp v=1 d=06 w=0", out_valid, out_data, out_wrap); end
        cycle(0, 8'h00, 1);
        checks++; if (xfer_count !== 16'd1) begin errors++; $display("FAIL single_count got %0d exp 1", xfer_count); end
        checks++; if (out_valid !== 1'b0 || out_data !== 8'h00) begin errors++; $display("FAIL single_empty got v=%b d=%h exp v=0 d=00", out_valid, out_data); end
    endtask

    task automatic test_wrap();
        do_reset();
        cycle(1, 8'hFF, 1);
        checks++; if (out_data !== 8'h00 || out_wrap !== 1'b1 || out_valid !== 1'b1) begin errors++; $display("FAIL wrap_ff got d=%h w=%b v=%b exp d=00 w=1 v=1", out_data, out_wrap, out_valid); end
        cycle(1, 8'hFE, 1);
        checks++; if (out_data !== 8'hFF || out_wrap !== 1'b0) begin errors++; $display("FAIL wrap_fe got d=%h w=%b exp d=ff w=0", out_data, out_wrap); end
        cycle(0, 8'h00, 1);
    endtask

    task automatic test_backpressure();
        logic [7:0] exp_seq[3] = '{8'h11, 8'h12, 8'h13};
        do_reset();
        cycle(1, 8'h10, 0);
        checks++; if (in_ready !== 1'b1 || out_data !== 8'h11) begin errors++; $display("FAIL bp_first got rdy=%b d=%h exp rdy=1 d=11", in_ready, out_data); end
        cycle(1, 8'h11, 0);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_in_ready got %b exp 0", in_ready); end
        for (int k = 0; k < 3; k++) begin
            cycle(1, 8'h12, 0);
            checks++; if (out_data !== 8'h11 || out_valid !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL bp_hold got d=%h v=%b rdy=%b exp d=11 v=1 rdy=0", out_data, out_valid, in_ready); end
        end
        for (int k = 0; k < 3; k++) begin
            checks++; if (out_valid !== 1'b1 || out_data !== exp_seq[k]) begin errors++; $display("FAIL bp_drain%0d got v=%b d=%h exp v=1 d=%h", k, out_valid, out_data, exp_seq[k]); end
            cycle(k < 2, 8'h12, 1);
        end
        checks++; if (out_valid !== 1'b0 || xfer_count !== 16'd3) begin errors++; $display("FAIL bp_end got v=%b cnt=%0d exp v=0 cnt=3", out_valid, xfer_count); end
    endtask

    task automatic test_stream();
        do_reset();
        for (int i = 0; i < 100; i++) begin
            cycle(1, 8'(i), 1);
            checks++; if (out_valid !== 1'b1 || out_data !== 8'(i + 1) || in_ready !== 1'b1) begin errors++; $display("FAIL stream%0d got v=%b d=%h rdy=%b exp v=1 d=%h rdy=1", i, out_valid, out_data, in_ready, 8'(i + 1)); end
        end
        cycle(0, 8'h00, 1);
        checks++; if (xfer_count !== 16'd100) begin errors++; $display("FAIL stream_count got %0d exp 100", xfer_count); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        cycle(1, 8'h20, 1);
        cycle(0, 8'h00, 1);
        cycle(1, 8'h30, 0);
        cycle(1, 8'h31, 0);
        checks++; if (in_ready !== 1'b0 || xfer_count !== 16'd1) begin errors++; $display("FAIL mid_full got rdy=%b cnt=%0d exp rdy=0 cnt=1", in_ready, xfer_count); end
        #2;
        reset = 1;
        #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0 || xfer_count !== 16'd0 || out_data !== 8'h00) begin errors++; $display("FAIL mid_async got v=%b rdy=%b cnt=%0d d=%h exp all 0", out_valid, in_ready, xfer_count, out_data); end
        q.delete();
        cnt = 0;
        cnt4 = 0;
        @(negedge clk);
        reset = 0;
        #1;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL mid_release got rdy=%b v=%b exp rdy=1 v=0", in_ready, out_valid); end
        cycle(1, 8'h40, 1);
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h41) begin errors++; $display("FAIL mid_next got v=%b d=%h exp v=1 d=41", out_valid, out_data); end
        cycle(0, 8'h00, 1);
        checks++; if (xfer_count !== 16'd1) begin errors++; $display("FAIL mid_count got %0d exp 1", xfer_count); end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 21; i++) begin
            cycle(i < 20, 8'(i), 1);
            checks++; if (xfer_count4 !== 4'(cnt4) || xfer_count !== 16'(cnt)) begin errors++; $display("FAIL sat%0d got c4=%0d c16=%0d exp c4=%0d c16=%0d", i, xfer_count4, xfer_count, cnt4, cnt); end
        end
        checks++; if (xfer_count4 !== 4'd15 || xfer_count !== 16'd20) begin errors++; $display("FAIL sat_end got c4=%0d c16=%0d exp 15/20", xfer_count4, xfer_count); end
    endtask

    task automatic test_random();
        logic ev, ew;
        logic [7:0] ed;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 3) != 0 ? (i % 64 < 40) : 1));
            ev = q.size() > 0;
            ed = ev ? q[0][7:0] : 8'h00;
            ew = ev ? q[0][8] : 1'b0;
            checks++; if (out_valid !== ev || out_data !== ed || out_wrap !== ew) begin errors++; $display("FAIL rand%0d_out got v=%b d=%h w=%b exp v=%b d=%h w=%b", i, out_valid, out_data, out_wrap, ev, ed, ew); end
            checks++; if (in_ready !== (q.size() < 2) || xfer_count !== 16'(cnt)) begin errors++; $display("FAIL rand%0d_ctl got rdy=%b cnt=%0d exp rdy=%b cnt=%0d", i, in_ready, xfer_count, q.size() < 2, cnt); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_wrap();
        test_backpressure();
        test_stream();
        test_reset_mid();
        test_saturation();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
